// File: rtl/fft_r2_sdf_bf_if.sv
// Stream-side port bundle for fft_r2_sdf_bf: complex sample input, registered result output.
interface fft_r2_sdf_bf_if #(
    parameter int DATA_WIDTH = 25
);
    logic                  ce;
    logic                  sync_i;
    logic [DATA_WIDTH-1:0] di_re;
    logic [DATA_WIDTH-1:0] di_im;
    logic [DATA_WIDTH:0]   data_o_re;
    logic [DATA_WIDTH:0]   data_o_im;
    logic                  valid_o;
    logic                  sync_o;

    modport master (
        output ce, sync_i, di_re, di_im,
        input  data_o_re, data_o_im, valid_o, sync_o
    );

    modport slave (
        input  ce, sync_i, di_re, di_im,
        output data_o_re, data_o_im, valid_o, sync_o
    );
endinterface

// File: rtl/fft_r2_sdf_bf.sv
// Radix-2 SDF decimation-in-frequency butterfly; the delay line is an external shift_reg of LEN=DELAY.
// Define FFT_BF_SCALE_EN to halve every sum/difference with round-half-up.
//
// state | meaning
// FILL  | delay line not yet holding a full first half; valid_o stays 0
// RUN   | every output register update carries a meaningful sample
module fft_r2_sdf_bf #(
    parameter int DATA_WIDTH = 25,
    parameter int DELAY      = 512
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fft_r2_sdf_bf_if.slave                bus,
    output logic                          sr_ce,
    output logic [2*(DATA_WIDTH+1)-1:0]   sr_di,
    input  logic [2*(DATA_WIDTH+1)-1:0]   sr_do
);
    localparam int IW = $clog2(DELAY) + 1;
    localparam int W1 = DATA_WIDTH + 1;
    localparam logic [IW-1:0] HALF = IW'(DELAY);

    typedef enum logic {FILL, RUN} state_t;

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_eff;
    logic          bfly;

    logic signed [W1-1:0] x_re, x_im, d_re, d_im;
    logic signed [W1-1:0] sum_re, sum_im, dif_re, dif_im;
    logic signed [W1-1:0] out_re, out_im;

    // One extra bit of headroom so the scaled difference can't wrap before the shift.
    function automatic logic signed [W1-1:0] bf_op(
        input logic signed [W1-1:0] a,
        input logic signed [W1-1:0] b,
        input logic                 sub
    );
        logic signed [W1:0] t;
        t = sub ? ((W1+1)'(a) - (W1+1)'(b)) : ((W1+1)'(a) + (W1+1)'(b));
`ifdef FFT_BF_SCALE_EN
        return W1'((t + 1) >>> 1);
`else
        return W1'(t);
`endif
    endfunction

    assign idx_eff = bus.sync_i ? '0 : idx;
    assign bfly    = idx_eff[IW-1];

    assign x_re = {bus.di_re[DATA_WIDTH-1], bus.di_re};
    assign x_im = {bus.di_im[DATA_WIDTH-1], bus.di_im};
    assign d_re = sr_do[2*W1-1:W1];
    assign d_im = sr_do[W1-1:0];

    assign sum_re = bf_op(d_re, x_re, 1'b0);
    assign sum_im = bf_op(d_im, x_im, 1'b0);
    assign dif_re = bf_op(d_re, x_re, 1'b1);
    assign dif_im = bf_op(d_im, x_im, 1'b1);

    assign out_re = bfly ? sum_re : d_re;
    assign out_im = bfly ? sum_im : d_im;

    assign sr_ce = bus.ce;
    assign sr_di = bfly ? {dif_re, dif_im} : {x_re, x_im};

    always_comb begin
        state_nx = state;
        if (state == FILL && idx_eff == HALF)
            state_nx = RUN;
        else if (state == RUN && bus.sync_i && idx != '0)
            state_nx = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            idx           <= '0;
            bus.data_o_re <= '0;
            bus.data_o_im <= '0;
            bus.valid_o   <= 1'b0;
            bus.sync_o    <= 1'b0;
        end else if (bus.ce) begin
            state         <= state_nx;
            idx           <= idx_eff + 1'b1;
            bus.data_o_re <= out_re;
            bus.data_o_im <= out_im;
            bus.valid_o   <= (state_nx == RUN);
            bus.sync_o    <= (state_nx == RUN) && (idx_eff == HALF);
        end
    end
endmodule

// File: tb/tb_fft_r2_sdf_bf.sv
// Bench for fft_r2_sdf_bf: vector tables, corner sequences and a random run against a frame-level model.
module tb_fft_r2_sdf_bf;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int W1 = DW + 1;

`ifdef FFT_BF_SCALE_EN
    localparam int SUM_A = 1,  SUM_B = -1, DIF_B = -2, FS_RE = 127, FS_IM = -128;
`else
    localparam int SUM_A = 2,  SUM_B = -2, DIF_B = -4, FS_RE = 254, FS_IM = -256;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_r2_sdf_bf_if #(.DATA_WIDTH(DW)) bus();
    logic          sr_ce;
    logic [2*W1-1:0] sr_di;
    logic [2*W1-1:0] sr_do;

    fft_r2_sdf_bf #(.DATA_WIDTH(DW), .DELAY(D)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sr_ce(sr_ce), .sr_di(sr_di), .sr_do(sr_do)
    );

    // External delay line: output is the value written exactly D enabled cycles ago.
    logic [2*W1-1:0] dl [D] = '{default: '0};
    logic [$clog2(D)-1:0] dl_ptr = '0;
    assign sr_do = dl[dl_ptr];
    always @(posedge clk) begin
        if (sr_ce) begin
            dl[dl_ptr] <= sr_di;
            dl_ptr     <= dl_ptr + 1'b1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: keeps whole frames and applies the butterfly definition directly.
    int m_idx;
    bit m_run;
    int cur_re [2*D];
    int cur_im [2*D];
    int prv_re [2*D];
    int prv_im [2*D];
    int e_re, e_im;
    bit e_valid, e_sync;

    function automatic int bf(input int a, input int b, input bit sub);
        int t;
        t = sub ? a - b : a + b;
`ifdef FFT_BF_SCALE_EN
        return (t + 1) >>> 1;
`else
        return t;
`endif
    endfunction

    task automatic model_reset();
        m_idx = 0; m_run = 0;
        e_re = 0; e_im = 0; e_valid = 0; e_sync = 0;
    endtask

    task automatic model_step(input bit sync, input int re, input int im);
        int k;
        k = sync ? 0 : m_idx;
        if (sync && m_idx != 0) m_run = 0;
        if (k == 0) begin
            prv_re = cur_re;
            prv_im = cur_im;
        end
        cur_re[k] = re;
        cur_im[k] = im;
        if (k == D) m_run = 1;
        e_valid = m_run;
        e_sync  = (k == D);
        if (k >= D) begin
            e_re = bf(cur_re[k-D], re, 1'b0);
            e_im = bf(cur_im[k-D], im, 1'b0);
        end else begin
            e_re = bf(prv_re[k], prv_re[k+D], 1'b1);
            e_im = bf(prv_im[k], prv_im[k+D], 1'b1);
        end
        m_idx = (k + 1) % (2*D);
    endtask

    function automatic int out_re();
        return int'($signed(bus.data_o_re));
    endfunction
    function automatic int out_im();
        return int'($signed(bus.data_o_im));
    endfunction

    // Called at a negedge; returns at the following negedge after comparing against the model.
    task automatic step(input bit ce, input bit sync, input int re, input int im);
        bus.ce     = ce;
        bus.sync_i = sync;
        bus.di_re  = DW'(re);
        bus.di_im  = DW'(im);
        @(posedge clk);
        if (ce) model_step(sync, re, im);
        @(negedge clk);
        bus.ce     = 1'b0;
        bus.sync_i = 1'b0;
        check("model valid_o", int'(bus.valid_o), int'(e_valid));
        check("model sync_o", int'(bus.sync_o), int'(e_sync));
        if (e_valid) begin
            check("model data_o_re", out_re(), e_re);
            check("model data_o_im", out_im(), e_im);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset data_o_re", out_re(), 0);
        check("reset valid_o", int'(bus.valid_o), 0);
        check("reset sync_o", int'(bus.sync_o), 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit ce;
        bit sync;
        int re;
        int im;
        bit chk;
        int exp_re;
        int exp_im;
        bit exp_valid;
        bit exp_sync;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit ce, input bit sync, input int re, input int im,
                       input bit chk, input int xr, input int xi, input bit xv, input bit xs);
        vec_t v;
        v.ce = ce; v.sync = sync; v.re = re; v.im = im;
        v.chk = chk; v.exp_re = xr; v.exp_im = xi; v.exp_valid = xv; v.exp_sync = xs;
        tbl.push_back(v);
    endtask

    task automatic build_basic(input bit stall);
        tbl.delete();
        for (int i = 0; i < 8; i++) begin
            add(1'b1, i == 0, i + 1, 0, i >= 4, SUM_A*i + SUM_B, 0, i >= 4, i == 4);
            if (stall && i == 5)
                for (int s = 0; s < 3; s++)
                    add(1'b0, 1'b0, 0, 0, 1'b1, SUM_A*5 + SUM_B, 0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 8; i++)
            add(1'b1, i == 0, 0, 0, 1'b1, (i < 4) ? DIF_B : 0, 0, 1'b1, i == 4);
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step(tbl[i].ce, tbl[i].sync, tbl[i].re, tbl[i].im);
            check({tag, " valid_o"}, int'(bus.valid_o), int'(tbl[i].exp_valid));
            check({tag, " sync_o"}, int'(bus.sync_o), int'(tbl[i].exp_sync));
            if (tbl[i].chk) begin
                check({tag, " data_o_re"}, out_re(), tbl[i].exp_re);
                check({tag, " data_o_im"}, out_im(), tbl[i].exp_im);
            end
        end
    endtask

    initial begin
        bus.ce = 1'b0; bus.sync_i = 1'b0; bus.di_re = '0; bus.di_im = '0;
        for (int i = 0; i < 2*D; i++) begin
            cur_re[i] = 0; cur_im[i] = 0; prv_re[i] = 0; prv_im[i] = 0;
        end
        model_reset();

        do_reset();
        build_basic(1'b0);
        run_table("basic");

        do_reset();
        build_basic(1'b1);
        run_table("stall");

        // Full-scale operands: sums need the extra output bit, differences cancel.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0 || i == 8, 127, -128);
            if (i >= 4 && i < 8) begin
                check("fullscale sum re", out_re(), FS_RE);
                check("fullscale sum im", out_im(), FS_IM);
            end else if (i >= 8) begin
                check("fullscale dif re", out_re(), 0);
                check("fullscale dif im", out_im(), 0);
            end
        end

        // Realign at index 6 of the second frame, then a fresh basic frame from that sample.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, i + 1, 0);
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 0, 0);
        check("realign pre valid_o", int'(bus.valid_o), 1);
        step(1'b1, 1'b1, 1, 0);
        check("realign valid_o drop", int'(bus.valid_o), 0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, i + 1, 0);
            check("realign valid_o", int'(bus.valid_o), int'(i >= 4));
            check("realign sync_o", int'(bus.sync_o), int'(i == 4));
            if (i >= 4) check("realign sum", out_re(), SUM_A*i + SUM_B);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, i == 0, 0, 0);
            check("realign dif", out_re(), DIF_B);
        end

        // Asynchronous reset in the middle of the BFLY half.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, i + 1, 0);
        check("pre-reset valid_o", int'(bus.valid_o), 1);
        check("pre-reset data_o_re", out_re(), SUM_A*5 + SUM_B);
        #2 rst_n = 1'b0;
        #1;
        check("async reset data_o_re", out_re(), 0);
        check("async reset valid_o", int'(bus.valid_o), 0);
        check("async reset sync_o", int'(bus.sync_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        build_basic(1'b0);
        run_table("after reset");

        // Random traffic with stalls, frame syncs and occasional realigns.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit ce, sync;
            int re, im;
            ce = ($urandom_range(0, 3) != 0);
            if (n == 0) sync = 1'b1;
            else if (m_idx == 0) sync = ($urandom_range(0, 1) != 0);
            else sync = ($urandom_range(0, 59) == 0);
            re = int'($urandom_range(0, 255)) - 128;
            im = int'($urandom_range(0, 255)) - 128;
            step(ce, sync, re, im);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
